alarm_controller: RTL and testbench
===================================

# alarm_controller

Downstream consumer of the time-keeping block. Compares the running BCD time (H1,H2,M1,M2) against a user-set BCD alarm time, and drives the ring output through an armed/ringing/snoozing state machine. Ringing ends on an explicit stop, on automatic timeout, or by snoozing to a computed wrap-around target time.

## Interface
- RING_TICKS, 60: number of `tick` pulses after which an unattended ring auto-stops (≥1)
- SNOOZE_MIN, 5: minutes added to the current time on snooze (1..59)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..7); the next snooze acts as stop

- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  alarm enable switch
- tick  in  1  one-cycle timebase pulse used for the ring timeout
- H1, H2, M1, M2  in  2/4/3/4  current time, BCD, from the time-keeping block
- AH1, AH2, AM1, AM2  in  2/4/3/4  alarm time, BCD
- stop  in  1  stop request, one-cycle pulse
- snooze  in  1  snooze request, one-cycle pulse
- ring  out  1  alarm sounding
- snoozing  out  1  snooze pending
- snooze_cnt  out  3  snoozes taken in the current alarm event

## Operation
- States: DISARMED, ARMED, RINGING, SNOOZING. `ring`=(state==RINGING). `snoozing`=(state==SNOOZING).
- Match signals are combinational:
  - `amatch`: {H1,H2,M1,M2}=={AH1,AH2,AM1,AM2}
  - `smatch`: current time == the stored snooze target
- `amatch_d` and `smatch_d` are registered copies of the match signals, updated every cycle. Trigger conditions:
  - alarm trigger = `amatch` & ~`amatch_d`
  - snooze trigger = `smatch` & ~`smatch_d`
- Transitions, in priority order:
  - `en`=0: go to DISARMED from any state. Clear `snooze_cnt` and the ring counter.
  - DISARMED: if `en`=1, go to ARMED.
  - ARMED: on alarm trigger, go to RINGING and clear the ring counter.
  - RINGING:
    - `stop`: go to ARMED and clear `snooze_cnt`. Stop wins over a simultaneous `snooze`.
    - `snooze` with `snooze_cnt`<MAX_SNOOZE: latch the target (current time + SNOOZE_MIN), increment `snooze_cnt`, go to SNOOZING.
    - `snooze` with `snooze_cnt`==MAX_SNOOZE: treated as stop.
    - `tick` when the ring counter ==RING_TICKS-1: go to ARMED and clear `snooze_cnt` (timeout).
    - any other `tick`: increment the ring counter.
  - SNOOZING:
    - `stop`: go to ARMED and clear `snooze_cnt`.
    - snooze trigger: go to RINGING and clear the ring counter.
    - alarm trigger: ignored.
- `stop` and `snooze` are ignored outside the states listed above.
- Snooze target arithmetic:
  - m = 10·M1+M2+SNOOZE_MIN
  - If m≥60: m -= 60 and increment the hour; hour 24 wraps to 00.
  - Store the result as BCD in the 2/4/3/4-bit target registers.
- Inputs are always legal BCD (hours 00–23, minutes 00–59). Behaviour for illegal codes is unspecified.
- Edge-based triggering means:
  - Stopping during the matching minute never re-triggers.
  - Enabling while the time already equals the alarm time does not ring.

## Timing
- Reset (rst=0) immediately forces:
  - state=DISARMED; `ring`=0, `snoozing`=0, `snooze_cnt`=0
  - ring counter=0; snooze target=00:00
  - `amatch_d`=1, `smatch_d`=1, so the block cannot trigger right after release
- Alarm trigger latency: time inputs become equal after edge k-1 → `ring`=1 after edge k.
- `stop` or `snooze` sampled at edge k → `ring`=0 after edge k.
- Timeout: `ring` falls after the edge that samples the RING_TICKS-th `tick` of the ring.
- `en` falling sampled at edge k → all outputs 0 after edge k.
- After DISARMED→ARMED, the first possible ring requires a fresh rising edge of the match.
- Reset mid-RINGING drops `ring` asynchronously. With the time still matching after release, there is no ring.

## Test plan
Bench parameters: RING_TICKS=4, SNOOZE_MIN=5, MAX_SNOOZE=2.

- Basic ring and stop: alarm 07:30, en=1, time 07:29→07:30 → `ring`=1 one edge later. Pulse `stop` → `ring`=0 next edge and stays 0 while the time holds 07:30.
- Timeout: ring as in the previous scenario, then 4 `tick` pulses → `ring`=0 after the 4th, `snooze_cnt`=0. No `tick` → `ring` holds indefinitely.
- Snooze with wrap: alarm 23:57, ring, pulse `snooze` → `snoozing`=1, `ring`=0, target 00:02. Time 23:58..00:01 → no ring. 00:02 → `ring`=1, `snooze_cnt`=1.
- Snooze limit: two snoozes taken (`snooze_cnt`=2), third `snooze` while ringing → ARMED, `ring`=0, `snoozing`=0, `snooze_cnt`=0. `stop` and `snooze` in the same cycle → stop behaviour.
- Enable drop and re-enable: `en`=0 mid-RINGING → `ring`=0 next edge. `en`=1 again while the time equals the alarm → no ring. Time moves off and back to the alarm → ring.
- Async reset: assert rst mid-RINGING between clock edges → `ring`=0 immediately. Release with the time still matching → no ring. Next genuine match edge → ring.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm controller: compares the running BCD time against a BCD alarm time and
// drives ring/snooze through an armed/ringing/snoozing state machine.
module alarm_controller #(
    parameter int RING_TICKS = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [1:0] H1,
    input  logic [3:0] H2,
    input  logic [2:0] M1,
    input  logic [3:0] M2,
    input  logic [1:0] AH1,
    input  logic [3:0] AH2,
    input  logic [2:0] AM1,
    input  logic [3:0] AM2,
    input  logic       stop,
    input  logic       snooze,
    output logic       ring,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);

    localparam int RCW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;

    typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZING} state_t;

    state_t           state_reg;
    logic             ring_reg;
    logic             snoozing_reg;
    logic [2:0]       snooze_cnt_reg;
    logic [RCW-1:0]   ring_cnt_reg;
    logic             amatch_d_reg;
    logic             smatch_d_reg;
    logic [1:0]       th1_reg;
    logic [3:0]       th2_reg;
    logic [2:0]       tm1_reg;
    logic [3:0]       tm2_reg;

    logic             amatch;
    logic             smatch;
    logic             alarm_trig;
    logic             snooze_trig;
    logic             ring_last;
    logic             snooze_at_limit;

    logic [6:0]       min_sum;
    logic [6:0]       min_new;
    logic [4:0]       hour_cur;
    logic [4:0]       hour_new;
    logic [1:0]       th1_next;
    logic [3:0]       th2_next;
    logic [2:0]       tm1_next;
    logic [3:0]       tm2_next;

    assign amatch = ({H1, H2, M1, M2} == {AH1, AH2, AM1, AM2});
    assign smatch = ({H1, H2, M1, M2} == {th1_reg, th2_reg, tm1_reg, tm2_reg});

    // Edge detection: a match that is already present never triggers.
    assign alarm_trig  = amatch & ~amatch_d_reg;
    assign snooze_trig = smatch & ~smatch_d_reg;

    assign ring_last       = (ring_cnt_reg == RCW'(RING_TICKS - 1));
    assign snooze_at_limit = (snooze_cnt_reg == 3'(MAX_SNOOZE));

    // Snooze target = current time + SNOOZE_MIN, wrapping minutes and hours.
    always_comb begin
        min_sum  = {4'd0, M1} * 7'd10 + {3'd0, M2} + 7'(SNOOZE_MIN);
        hour_cur = {3'd0, H1} * 5'd10 + {1'b0, H2};
        min_new  = min_sum;
        hour_new = hour_cur;
        if (min_sum >= 7'd60) begin
            min_new  = min_sum - 7'd60;
            hour_new = (hour_cur == 5'd23) ? 5'd0 : hour_cur + 5'd1;
        end
        tm1_next = 3'(min_new / 7'd10);
        tm2_next = 4'(min_new % 7'd10);
        th1_next = 2'(hour_new / 5'd10);
        th2_next = 4'(hour_new % 5'd10);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= DISARMED;
            ring_reg       <= 1'b0;
            snoozing_reg   <= 1'b0;
            snooze_cnt_reg <= 3'd0;
            ring_cnt_reg   <= '0;
            amatch_d_reg   <= 1'b1;
            smatch_d_reg   <= 1'b1;
            th1_reg        <= 2'd0;
            th2_reg        <= 4'd0;
            tm1_reg        <= 3'd0;
            tm2_reg        <= 4'd0;
        end else begin
            amatch_d_reg <= amatch;
            smatch_d_reg <= smatch;
            if (!en) begin
                state_reg      <= DISARMED;
                ring_reg       <= 1'b0;
                snoozing_reg   <= 1'b0;
                snooze_cnt_reg <= 3'd0;
                ring_cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    DISARMED: begin
                        state_reg <= ARMED;
                    end
                    ARMED: begin
                        if (alarm_trig) begin
                            state_reg    <= RINGING;
                            ring_reg     <= 1'b1;
                            ring_cnt_reg <= '0;
                        end
                    end
                    RINGING: begin
                        // An exhausted snooze budget turns snooze into stop.
                        if (stop || (snooze && snooze_at_limit)) begin
                            state_reg      <= ARMED;
                            ring_reg       <= 1'b0;
                            snooze_cnt_reg <= 3'd0;
                        end else if (snooze) begin
                            state_reg      <= SNOOZING;
                            ring_reg       <= 1'b0;
                            snoozing_reg   <= 1'b1;
                            snooze_cnt_reg <= snooze_cnt_reg + 3'd1;
                            th1_reg        <= th1_next;
                            th2_reg        <= th2_next;
                            tm1_reg        <= tm1_next;
                            tm2_reg        <= tm2_next;
                        end else if (tick) begin
                            if (ring_last) begin
                                state_reg      <= ARMED;
                                ring_reg       <= 1'b0;
                                snooze_cnt_reg <= 3'd0;
                            end else begin
                                ring_cnt_reg <= ring_cnt_reg + RCW'(1);
                            end
                        end
                    end
                    SNOOZING: begin
                        if (stop) begin
                            state_reg      <= ARMED;
                            snoozing_reg   <= 1'b0;
                            snooze_cnt_reg <= 3'd0;
                        end else if (snooze_trig) begin
                            state_reg    <= RINGING;
                            ring_reg     <= 1'b1;
                            snoozing_reg <= 1'b0;
                            ring_cnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= DISARMED;
                    end
                endcase
            end
        end
    end

    assign ring       = ring_reg;
    assign snoozing   = snoozing_reg;
    assign snooze_cnt = snooze_cnt_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: stimulus pushes hand-computed
// expectations, a separate monitor pops and compares after each sample point.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] H1 = '0;
    logic [3:0] H2 = '0;
    logic [2:0] M1 = '0;
    logic [3:0] M2 = '0;
    logic [1:0] AH1 = '0;
    logic [3:0] AH2 = '0;
    logic [2:0] AM1 = '0;
    logic [3:0] AM2 = '0;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;
    logic       ring;
    logic       snoozing;
    logic [2:0] snooze_cnt;

    logic       en_v = 1'b0;
    logic       rst_v = 1'b0;

    typedef struct {
        logic       r;
        logic       s;
        logic [2:0] c;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alarm_controller #(
        .RING_TICKS(4),
        .SNOOZE_MIN(5),
        .MAX_SNOOZE(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .H1(H1), .H2(H2), .M1(M1), .M2(M2),
        .AH1(AH1), .AH2(AH2), .AM1(AM1), .AM2(AM2),
        .stop(stop), .snooze(snooze),
        .ring(ring), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation consumed per sample point (clock edge or reset assertion).
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({ring, snoozing, snooze_cnt} !== {e.r, e.s, e.c}) begin
                    errors++;
                    $display("FAIL %s: got ring=%b snoozing=%b cnt=%0d, expected ring=%b snoozing=%b cnt=%0d",
                             e.nm, ring, snoozing, snooze_cnt, e.r, e.s, e.c);
                end else begin
                    $display("ok   %s: ring=%b snoozing=%b cnt=%0d", e.nm, ring, snoozing, snooze_cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic r, input logic s, input logic [2:0] c, input string nm);
        exp_t e;
        e.r = r;
        e.s = s;
        e.c = c;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    // t is BCD hhmm, e.g. 16'h2357.
    task automatic step(input logic [15:0] t, input logic s_stop, input logic s_snooze,
                        input logic s_tick, input logic e_ring, input logic e_snz,
                        input logic [2:0] e_cnt, input string nm);
        @(negedge clk);
        rst    = rst_v;
        en     = en_v;
        H1     = t[13:12];
        H2     = t[11:8];
        M1     = t[6:4];
        M2     = t[3:0];
        stop   = s_stop;
        snooze = s_snooze;
        tick   = s_tick;
        push_exp(e_ring, e_snz, e_cnt, nm);
    endtask

    task automatic set_alarm(input logic [15:0] t);
        AH1 = t[13:12];
        AH2 = t[11:8];
        AM1 = t[6:4];
        AM2 = t[3:0];
    endtask

    initial begin
        set_alarm(16'h0730);

        // Reset state
        rst_v = 1'b0; en_v = 1'b0;
        step(16'h0729, 0, 0, 0, 0, 0, 3'd0, "reset_0");
        step(16'h0729, 0, 0, 0, 0, 0, 3'd0, "reset_1");
        rst_v = 1'b1;
        step(16'h0729, 0, 0, 0, 0, 0, 3'd0, "release_disarmed");

        // Basic ring and stop
        en_v = 1'b1;
        step(16'h0729, 0, 0, 0, 0, 0, 3'd0, "arm");
        step(16'h0729, 0, 0, 0, 0, 0, 3'd0, "armed_idle");
        step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "basic_ring");
        step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "basic_ring_hold");
        step(16'h0730, 1, 0, 0, 0, 0, 3'd0, "basic_stop");
        for (int i = 0; i < 3; i++) step(16'h0730, 0, 0, 0, 0, 0, 3'd0, "stop_no_retrigger");

        // Timeout after 4 ticks
        step(16'h0731, 0, 0, 0, 0, 0, 3'd0, "time_off");
        step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "to_ring");
        step(16'h0730, 0, 0, 1, 1, 0, 3'd0, "to_tick1");
        step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "to_gap");
        step(16'h0730, 0, 0, 1, 1, 0, 3'd0, "to_tick2");
        step(16'h0730, 0, 0, 1, 1, 0, 3'd0, "to_tick3");
        step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "to_gap2");
        step(16'h0730, 0, 0, 1, 0, 0, 3'd0, "to_tick4_timeout");
        step(16'h0730, 0, 0, 0, 0, 0, 3'd0, "to_after");

        // No tick: ring holds
        step(16'h0731, 0, 0, 0, 0, 0, 3'd0, "hold_off");
        step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "hold_ring");
        for (int i = 0; i < 6; i++) step(16'h0730, 0, 0, 0, 1, 0, 3'd0, "hold_no_tick");
        step(16'h0730, 1, 0, 0, 0, 0, 3'd0, "hold_stop");

        // Snooze with midnight wrap: 23:57 + 5 -> 00:02
        set_alarm(16'h2357);
        step(16'h2356, 0, 0, 0, 0, 0, 3'd0, "wrap_pre");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "wrap_ring");
        step(16'h2357, 0, 1, 0, 0, 1, 3'd1, "wrap_snooze");
        step(16'h2358, 0, 0, 0, 0, 1, 3'd1, "wrap_wait_2358");
        step(16'h2359, 0, 0, 0, 0, 1, 3'd1, "wrap_wait_2359");
        step(16'h0000, 0, 0, 0, 0, 1, 3'd1, "wrap_wait_0000");
        step(16'h0001, 0, 0, 0, 0, 1, 3'd1, "wrap_wait_0001");
        step(16'h0002, 0, 0, 0, 1, 0, 3'd1, "wrap_target_ring");

        // Snooze limit: second snooze to 00:07, third acts as stop
        step(16'h0002, 0, 1, 0, 0, 1, 3'd2, "limit_snooze2");
        step(16'h0003, 0, 0, 0, 0, 1, 3'd2, "limit_wait");
        step(16'h0006, 0, 0, 0, 0, 1, 3'd2, "limit_wait_0006");
        step(16'h0007, 0, 0, 0, 1, 0, 3'd2, "limit_ring");
        step(16'h0007, 0, 1, 0, 0, 0, 3'd0, "limit_snooze3_stop");
        step(16'h0007, 0, 0, 0, 0, 0, 3'd0, "limit_armed");

        // stop and snooze together -> stop
        step(16'h2356, 0, 0, 0, 0, 0, 3'd0, "both_pre");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "both_ring");
        step(16'h2357, 1, 1, 0, 0, 0, 3'd0, "both_stop_wins");
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "both_after");

        // stop while snoozing
        step(16'h2356, 0, 0, 0, 0, 0, 3'd0, "sstop_pre");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "sstop_ring");
        step(16'h2357, 0, 1, 0, 0, 1, 3'd1, "sstop_snooze");
        step(16'h2358, 1, 0, 0, 0, 0, 3'd0, "sstop_stop");

        // Enable drop and re-enable
        step(16'h2356, 0, 0, 0, 0, 0, 3'd0, "en_pre");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "en_ring");
        en_v = 1'b0;
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "en_drop");
        en_v = 1'b1;
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "en_rearm_matching");
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "en_no_ring");
        step(16'h2358, 0, 0, 0, 0, 0, 3'd0, "en_time_off");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "en_fresh_ring");
        step(16'h2357, 0, 1, 0, 0, 1, 3'd1, "en_snooze");
        en_v = 1'b0;
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "en_drop_snoozing");
        en_v = 1'b1;
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "en_rearm2");

        // Async reset mid-ring
        step(16'h2358, 0, 0, 0, 0, 0, 3'd0, "ar_pre");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "ar_ring");
        @(negedge clk);
        push_exp(1'b0, 1'b0, 3'd0, "ar_async_drop");
        #2;
        rst = 1'b0;
        rst_v = 1'b0;
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "ar_held");
        rst_v = 1'b1;
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "ar_release");
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "ar_no_ring");
        step(16'h2357, 0, 0, 0, 0, 0, 3'd0, "ar_no_ring2");
        step(16'h2358, 0, 0, 0, 0, 0, 3'd0, "ar_off");
        step(16'h2357, 0, 0, 0, 1, 0, 3'd0, "ar_fresh_ring");
        step(16'h2357, 1, 0, 0, 0, 0, 3'd0, "ar_stop");

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
